i2c_target: RTL

I2C target (responder) for the FPGA's own I2C bus pins, the counterpart of the CPU-side I2C initiator. Oversamples SCL/SDA in the system clock domain, detects START/STOP, matches a 7-bit address, and maps bus transfers onto a byte-wide register port with an auto-incrementing 8-bit pointer. Owned by the same CPU subsystem; register storage lives outside this block.

---
 rtl/i2c_target.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match and a
// byte-wide register port with an auto-incrementing pointer. Optional macro I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target #(
    parameter logic [6:0] ADDRESS = 7'h50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       busy,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_strobe,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } state_t;

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_s;
    logic       sda_s;
    logic       scl_f;
    logic       sda_f;
    logic       scl_q;
    logic       sda_q;

    // Synchronizers and edge registers idle high so reset release never fakes an edge.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_q    <= scl_f;
            sda_q    <= sda_f;
        end
    end

    assign scl_s = scl_sync[1];
    assign sda_s = sda_sync[1];

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;
    logic       scl_hold;
    logic       sda_hold;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_hold <= 1'b1;
            sda_hold <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_s};
            sda_hist <= {sda_hist[0], sda_s};
            scl_hold <= scl_f;
            sda_hold <= sda_f;
        end
    end

    // Filtered value follows the input only once three consecutive samples agree.
    // NOTE: assigning a default first keeps always_comb from inferring a latch.
    always_comb begin
        scl_f = scl_hold;
        sda_f = sda_hold;
        if (scl_hist == {2{scl_s}}) scl_f = scl_s;
        if (sda_hist == {2{sda_s}}) sda_f = sda_s;
    end
`else
    assign scl_f = scl_s;
    assign sda_f = sda_s;
`endif

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

    state_t     state;
    logic [7:0] shift;
    logic [3:0] bit_cnt;
    logic [7:0] pointer;
    logic       rw;
    logic       ack_phase;
    logic       rd_load;
    logic [7:0] byte_in;

    assign byte_in = {shift[6:0], sda_f};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            pointer   <= '0;
            rw        <= 1'b0;
            ack_phase <= 1'b0;
            rd_load   <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_strobe <= 1'b0;
            rd_addr   <= '0;
        end else begin
            wr_valid  <= 1'b0;
            rd_strobe <= 1'b0;
            rd_load   <= 1'b0;
            if (rd_load) shift <= rd_data;

            if (start_det) begin
                state     <= ADDR;
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
                sda_oe    <= 1'b0;
            end else if (stop_det) begin
                state     <= IDLE;
                ack_phase <= 1'b0;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise) begin
                            shift   <= byte_in;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt   <= '0;
                                ack_phase <= 1'b0;
                                if (state == ADDR) begin
                                    if (byte_in[7:1] == ADDRESS) begin
                                        state <= ADDR_ACK;
                                        rw    <= byte_in[0];
                                        busy  <= 1'b1;
                                    end else begin
                                        state <= IGNORE;
                                        busy  <= 1'b0;
                                    end
                                end else if (state == PTR) begin
                                    pointer <= byte_in;
                                    state   <= PTR_ACK;
                                end else begin
                                    wr_valid <= 1'b1;
                                    wr_addr  <= pointer;
                                    wr_data  <= byte_in;
                                    pointer  <= pointer + 8'd1;
                                    state    <= WDATA_ACK;
                                end
                            end
                        end
                    end

                    // First SCL fall starts driving ACK, second fall ends the ACK bit.
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        if (scl_rise && state == ADDR_ACK && rw) begin
                            rd_strobe <= 1'b1;
                            rd_addr   <= pointer;
                            rd_load   <= 1'b1;
                        end
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_oe    <= 1'b1;
                                ack_phase <= 1'b1;
                            end else begin
                                ack_phase <= 1'b0;
                                bit_cnt   <= '0;
                                if (state == ADDR_ACK && rw) begin
                                    state  <= RDATA;
                                    sda_oe <= ~shift[7];
                                end else begin
                                    sda_oe <= 1'b0;
                                    state  <= (state == ADDR_ACK) ? PTR : WDATA;
                                end
                            end
                        end
                    end

                    RDATA: begin
                        if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                state     <= RDATA_ACK;
                                sda_oe    <= 1'b0;
                                ack_phase <= 1'b0;
                            end else begin
                                shift  <= {shift[6:0], 1'b0};
                                sda_oe <= ~shift[6];
                            end
                        end
                    end

                    // ack_phase here records that the initiator acknowledged the byte.
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            if (!sda_f) begin
                                ack_phase <= 1'b1;
                                pointer   <= pointer + 8'd1;
                                rd_addr   <= pointer + 8'd1;
                                rd_strobe <= 1'b1;
                                rd_load   <= 1'b1;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                        if (scl_fall && ack_phase) begin
                            state     <= RDATA;
                            ack_phase <= 1'b0;
                            bit_cnt   <= '0;
                            sda_oe    <= ~shift[7];
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

endmodule
